wide_add_seq: RTL and testbench

Multi-cycle wide-adder sequencer. It computes a W-bit sum with carry-in by stepping one N-bit ripple-carry chunk adder across W/N chunks, one chunk per clock, LSB chunk first. Operands enter and results leave through valid/ready handshakes. It sits beside the single-cycle datapath wherever a sum wider than the native adder is needed, such as 64-bit counters or address arithmetic, so that full-width carry chains stay off the critical path.

---
 rtl/wide_add_seq.sv | 135 +++++++++++++
 tb/tb_wide_add_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: steps one N-bit ripple-carry chunk adder across W/N chunks,
// LSB chunk first, with valid/ready handshakes on operands and result.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// RUN    | adding one chunk per cycle, carry held in c_q
// DONE   | result presented with out_valid, held until out_ready
module wide_add_seq #(
  parameter int W = 64,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          c_q, c_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;

  logic [N-1:0]  a_chunk, b_chunk, s_chunk;
  logic          c_chunk;
  logic          c_msb;
  logic          last_chunk;

  // Only one N-bit adder exists; the inter-chunk carry always passes through c_q.
  always_comb begin
    a_chunk              = a_q[int'(idx_q) * N +: N];
    b_chunk              = b_q[int'(idx_q) * N +: N];
    {c_chunk, s_chunk}   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, c_q};
    c_msb                = a_chunk[N-1] ^ b_chunk[N-1] ^ s_chunk[N-1];
    last_chunk           = (idx_q == LAST_IDX);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q) * N +: N] = s_chunk;
        c_d   = c_chunk;
        idx_d = idx_q + IW'(1);
        if (last_chunk) begin
          cout_d      = c_chunk;
          ovf_d       = c_msb ^ c_chunk;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // sum/cout/ovf deliberately keep their values after the handshake
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      c_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq (W=64, N=16): directed scenarios plus a randomized
// back-to-back run, all results checked against a queue of golden 65-bit sums.
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  wide_add_seq #(.W(64), .N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] f;
    exp_t r;
    f    = {1'b0, x} + {1'b0, y} + 65'(c);
    r.s  = f[63:0];
    r.co = f[64];
    r.ov = (x[63] == y[63]) && (f[63] != x[63]);
    return r;
  endfunction

  // Presents one operand set for a single edge while the DUT is idle; scrambles the
  // operand pins afterwards so a missed capture shows up in the result.
  task automatic drive_accept(input logic [63:0] op_a, input logic [63:0] op_b, input logic op_c);
    a        = op_a;
    b        = op_b;
    cin      = op_c;
    in_valid = 1'b1;
    exp_q.push_back(make_exp(op_a, op_b, op_c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    cin      = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, busy, in_ready} !== {1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values got ov=%b sum=%h cout=%b ovf=%b busy=%b in_ready=%b want 0 0 0 0 0 1",
               out_valid, sum, cout, ovf, busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple();
    int   lat;
    exp_t e;
    drive_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    total++;
    if ({busy, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL ripple_busy got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL ripple_latency got %0d want 4", lat);
    end
    e = exp_q.pop_front();
    total++;
    if ({sum, cout, ovf} !== {64'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ripple_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, e.s, e.co, e.ov);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, sum, cout} !== {1'b0, 1'b1, 64'h0, 1'b1}) begin
      bad++;
      $display("FAIL ripple_release got ov=%b in_ready=%b sum=%h cout=%b want 0 1 0 1",
               out_valid, in_ready, sum, cout);
    end
  endtask

  task automatic test_ovf_cin();
    logic [63:0] va[3];
    logic [63:0] vb[3];
    logic        vc[3];
    logic [65:0] want[3];
    int          lat;
    exp_t        e;
    va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
    want[0] = {64'h8000_0000_0000_0000, 1'b0, 1'b1};
    va[1] = 64'h0; vb[1] = 64'h0; vc[1] = 1'b1;
    want[1] = {64'h1, 1'b0, 1'b0};
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 1'b1;
    want[2] = {64'h1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_accept(va[i], vb[i], vc[i]);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      e = exp_q.pop_front();
      total++;
      if ({sum, cout, ovf} !== want[i] || {e.s, e.co, e.ov} !== want[i]) begin
        bad++;
        $display("FAIL ovf_cin[%0d] got sum=%h cout=%b ovf=%b want %h", i, sum, cout, ovf, want[i]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    drive_accept(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    // a competing request sits on the input for the whole stall
    a        = 64'h1111_2222_3333_4444;
    b        = 64'h0000_0000_0000_0005;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, e.s, e.co, e.ov}) begin
        bad++;
        $display("FAIL stall_hold[%0d] got ov=%b in_ready=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                 i, out_valid, in_ready, sum, cout, ovf, e.s, e.co, e.ov);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, busy, sum} !== {1'b0, 1'b1, 1'b0, e.s}) begin
      bad++;
      $display("FAIL stall_handshake got ov=%b in_ready=%b busy=%b sum=%h want 0 1 0 %h",
               out_valid, in_ready, busy, sum, e.s);
    end
    exp_q.push_back(make_exp(a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0;
    total++;
    if ({busy, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL stall_next_accept got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    total++;
    if (lat !== 4 || {sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
      bad++;
      $display("FAIL stall_next_result got lat=%0d sum=%h cout=%b ovf=%b want lat=4 %h %b %b",
               lat, sum, cout, ovf, e.s, e.co, e.ov);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    exp_t e;
    a = 64'h0000_0000_0000_1111; b = 64'h0000_0000_0000_2222; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, sum[15:0]} !== {1'b1, 16'h3333}) begin
      bad++;
      $display("FAIL mid_run got busy=%b sum_lo=%h want 1 3333", busy, sum[15:0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, busy, in_ready} !== {1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_async got ov=%b sum=%h cout=%b ovf=%b busy=%b in_ready=%b want 0 0 0 0 0 1",
               out_valid, sum, cout, ovf, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_result got out_valid seen=%b want 0", seen);
    end
    drive_accept(64'hDEAD_BEEF_0000_FFFF, 64'h2152_4111_FFFF_0001, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    total++;
    if (lat !== 4 || {sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
      bad++;
      $display("FAIL mid_reset_recover got lat=%0d sum=%h cout=%b ovf=%b want lat=4 %h %b %b",
               lat, sum, cout, ovf, e.s, e.co, e.ov);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   pushed;
    int   checked;
    int   cyc;
    exp_t e;
    pushed  = 0;
    checked = 0;
    cyc     = 0;
    while (checked < 1000 && cyc < 40000) begin
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: a[62:0] = '1;
        1: b = ~a;
        default: ;
      endcase
      cin       = 1'($urandom);
      in_valid  = (pushed < 1000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      if (in_valid && in_ready) begin
        exp_q.push_back(make_exp(a, b, cin));
        pushed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected got sum=%h with no operation outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            bad++;
            $display("FAIL rand_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     checked, sum, cout, ovf, e.s, e.co, e.ov);
          end
        end
        checked++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (checked !== 1000) begin
      bad++;
      $display("FAIL rand_count got %0d results want 1000", checked);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_ovf_cin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
